// File: rtl/pattern_gen.sv
// HDMI bring-up test-pattern source: bars, grey ramp, checkerboard, moving box.
// Latency: 1 clkin cycle, in_* -> out_*/r/g/b, all outputs registered.
// Backpressure: none, one pixel per cycle, never stalls.
module pattern_gen #(
  parameter int   H_ACTIVE = 1280,
  parameter int   V_ACTIVE = 720,
  parameter int   BAR_W    = 160,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic       clkin,
  input  logic       rstin,
  input  logic [1:0] mode,
  input  logic       in_hs,
  input  logic       in_vs,
  input  logic       in_de,
  output logic       out_hs,
  output logic       out_vs,
  output logic       out_de,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic [7:0] frame_cnt
);

  localparam logic [2:0]  BAR_LAST    = 3'(H_ACTIVE / BAR_W - 1);
  localparam logic [7:0]  BAR_PX_LAST = 8'(BAR_W - 1);
  localparam logic [10:0] BOX_T       = 11'(V_ACTIVE / 2 - 32);
  localparam logic [10:0] CNT_MAX     = 11'h7ff;
  localparam logic [23:0] WHITE       = 24'hffffff;

  logic        vs_q;
  logic        de_q;
  logic [10:0] x;
  logic [10:0] y;
  logic [7:0]  bar_px;
  logic [2:0]  bar_idx;
  logic [1:0]  mode_q;

  logic        fs;
  logic        le;
  logic [10:0] box_dx;
  logic [10:0] box_dy;
  logic [23:0] pix;

  assign fs = (in_vs == SYNC_POL) && (vs_q != SYNC_POL);
  assign le = !in_de && de_q;

  // Unsigned wrap makes pixels left of / above the box look far away.
  assign box_dx = x - {1'b0, frame_cnt, 2'b00};
  assign box_dy = y - BOX_T;

  always_comb begin
    pix = '0;
    if (in_de) begin
      case (mode_q)
        2'd0: begin
          case (bar_idx)
            3'd0:    pix = 24'hffffff;
            3'd1:    pix = 24'hffff00;
            3'd2:    pix = 24'h00ffff;
            3'd3:    pix = 24'h00ff00;
            3'd4:    pix = 24'hff00ff;
            3'd5:    pix = 24'hff0000;
            3'd6:    pix = 24'h0000ff;
            default: pix = 24'h000000;
          endcase
        end
        2'd1:    pix = {3{x[7:0]}};
        2'd2:    pix = (x[5] ^ y[5]) ? WHITE : 24'h000000;
        default: pix = (box_dx < 11'd64 && box_dy < 11'd64) ? WHITE : 24'h000000;
      endcase
    end
  end

  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
      out_hs    <= 1'b0;
      out_vs    <= 1'b0;
      out_de    <= 1'b0;
      r         <= '0;
      g         <= '0;
      b         <= '0;
      x         <= '0;
      y         <= '0;
      bar_px    <= '0;
      bar_idx   <= '0;
      mode_q    <= '0;
      frame_cnt <= '0;
    end else begin
      vs_q      <= in_vs;
      de_q      <= in_de;
      out_hs    <= in_hs;
      out_vs    <= in_vs;
      out_de    <= in_de;
      {r, g, b} <= pix;

      if (le) begin
        x       <= '0;
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (in_de) begin
        if (x != CNT_MAX) x <= x + 11'd1;
        if (bar_px == BAR_PX_LAST) begin
          bar_px <= '0;
          if (bar_idx != BAR_LAST) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_px <= bar_px + 8'd1;
        end
      end

      // Frame start beats a coincident line end so a new frame always begins at line 0.
      if (fs)                          y <= '0;
      else if (le && y != CNT_MAX)     y <= y + 11'd1;

      if (fs) begin
        frame_cnt <= frame_cnt + 8'd1;
        mode_q    <= mode;
      end
    end
  end

endmodule
